// File: rtl/parity_frame_scheduler.sv
// parity_frame_scheduler
// Shares one odd-parity generator between two requesters. A granted 3-bit
// word is streamed MSB-first as ASCII '0'/'1' characters followed by a
// separator slot; the generator's parity character is captured one cycle
// later and returned as a 4-bit frame {word, parity} with source ID and an
// error flag. The capture cycle overlaps the next frame's first bit slot, so
// back-to-back frames run at one per four cycles.
module parity_frame_scheduler #(
  parameter logic [7:0] CHAR_ZERO = 8'h30,
  parameter logic [7:0] CHAR_ONE  = 8'h31,
  parameter logic [7:0] CHAR_SEP  = 8'h20,
  parameter logic [7:0] CHAR_IDLE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] gen_i,
  input  logic [7:0] gen_o,
  output logic       frame_valid,
  output logic [3:0] frame_data,
  output logic       frame_src,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_SEP  = 3'd4
  } state_t;

  // Character presented to the generator for a given state and word.
  function automatic logic [7:0] state_char(input state_t st, input logic [2:0] word);
    logic [7:0] ch;
    ch = CHAR_IDLE;
    case (st)
      ST_IDLE: ch = CHAR_IDLE;
      ST_B0:   ch = word[2] ? CHAR_ONE : CHAR_ZERO;
      ST_B1:   ch = word[1] ? CHAR_ONE : CHAR_ZERO;
      ST_B2:   ch = word[0] ? CHAR_ONE : CHAR_ZERO;
      ST_SEP:  ch = CHAR_SEP;
      default: ch = CHAR_IDLE;
    endcase
    return ch;
  endfunction

  // Odd-parity character the generator must return for a word: '1' when the
  // word holds an even number of ones, '0' otherwise.
  function automatic logic [7:0] odd_parity_char(input logic [2:0] word);
    return (~^word) ? CHAR_ONE : CHAR_ZERO;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_word;
  logic        r_src;
  logic        r_last_grant;
  logic [2:0]  r_cap_word;
  logic        r_cap_src;
  logic        r_cap_pending;
  logic [7:0]  r_gen_i;
  logic        r_frame_valid;
  logic [3:0]  r_frame_data;
  logic        r_frame_src;
  logic        r_frame_err;

  logic        w_accept;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_hs;
  logic [2:0]  w_hs_word;
  logic [2:0]  w_word_next;

  // Round-robin: on contention the requester that did not win last time wins.
  assign w_accept    = (r_state == ST_IDLE) || (r_state == ST_SEP);
  assign w_grant0    = req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1    = req1_valid && (!req0_valid || !r_last_grant);
  assign w_ready0    = w_accept && w_grant0;
  assign w_ready1    = w_accept && w_grant1;
  assign w_hs        = w_ready0 || w_ready1;
  assign w_hs_word   = w_ready1 ? req1_data : req0_data;
  assign w_word_next = w_hs ? w_hs_word : r_word;

  // Next-state logic: bit slots advance unconditionally; accept windows
  // either start a new frame or fall back to idle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_next_state = ST_B0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_B0:   w_next_state = ST_B1;
      ST_B1:   w_next_state = ST_B2;
      ST_B2:   w_next_state = ST_SEP;
      ST_SEP: begin
        if (w_hs) begin
          w_next_state = ST_B0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the accepted word, its source and the round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word       <= 3'd0;
      r_src        <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_hs) begin
      r_word       <= w_hs_word;
      r_src        <= w_ready1;
      r_last_grant <= w_ready1;
    end else begin
      r_word       <= r_word;
      r_src        <= r_src;
      r_last_grant <= r_last_grant;
    end
  end

  // Registered generator stream: the character matching the state entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gen_i <= CHAR_IDLE;
    end else begin
      r_gen_i <= state_char(w_next_state, w_word_next);
    end
  end

  // Snapshot the word at the separator so the next frame can reuse r_word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_word    <= 3'd0;
      r_cap_src     <= 1'b0;
      r_cap_pending <= 1'b0;
    end else if (r_state == ST_SEP) begin
      r_cap_word    <= r_word;
      r_cap_src     <= r_src;
      r_cap_pending <= 1'b1;
    end else begin
      r_cap_word    <= r_cap_word;
      r_cap_src     <= r_cap_src;
      r_cap_pending <= 1'b0;
    end
  end

  // Build the frame from the parity character present in the capture cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_valid <= 1'b0;
      r_frame_data  <= 4'd0;
      r_frame_src   <= 1'b0;
      r_frame_err   <= 1'b0;
    end else if (r_cap_pending) begin
      r_frame_valid <= 1'b1;
      r_frame_data  <= {r_cap_word, (gen_o == CHAR_ONE)};
      r_frame_src   <= r_cap_src;
      r_frame_err   <= (gen_o != odd_parity_char(r_cap_word));
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_data  <= r_frame_data;
      r_frame_src   <= r_frame_src;
      r_frame_err   <= r_frame_err;
    end
  end

  assign req0_ready  = w_ready0;
  assign req1_ready  = w_ready1;
  assign gen_i       = r_gen_i;
  assign frame_valid = r_frame_valid;
  assign frame_data  = r_frame_data;
  assign frame_src   = r_frame_src;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != ST_IDLE) || r_cap_pending;

endmodule
